// File: rtl/colour_wheel_ctrl_if.sv
// rtl/colour_wheel_ctrl_if.sv - key/switch and drawing-datapath signals of the colour-wheel controller
interface colour_wheel_ctrl_if #(
    parameter int IDX_W        = 3,
    parameter int SCORE_DIGITS = 2,
    parameter int Y_W          = 7,
    parameter int SPEED_W      = 7
);
    logic                      go;
    logic                      left;
    logic                      right;
    logic [Y_W-1:0]            ball_y;
    logic [IDX_W-1:0]          ball_idx;
    logic                      draw_done;
    logic                      frame_tick;
    logic [IDX_W-1:0]          wheel_pos;
    logic                      game_en;
    logic                      new_col_en;
    logic                      ball_en;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [4*SCORE_DIGITS-1:0] hscore;
    logic [SPEED_W-1:0]        speed;
    logic                      game_over;
    logic [2:0]                state_dbg;

    // controller side
    modport master (
        input  go, left, right, ball_y, ball_idx, draw_done, frame_tick,
        output wheel_pos, game_en, new_col_en, ball_en, score, hscore,
               speed, game_over, state_dbg
    );

    // keys and drawing datapath side
    modport slave (
        output go, left, right, ball_y, ball_idx, draw_done, frame_tick,
        input  wheel_pos, game_en, new_col_en, ball_en, score, hscore,
               speed, game_over, state_dbg
    );
endinterface

// File: rtl/colour_wheel_ctrl.sv
// rtl/colour_wheel_ctrl.sv - colour-wheel game sequencer, wheel rotation, BCD score and speed level
module colour_wheel_ctrl #(
    parameter int NUM_COLOURS  = 4,
    parameter int IDX_W        = 3,
    parameter int SCORE_DIGITS = 2,
    parameter int Y_W          = 7,
    parameter int Y_HIT        = 119,
    parameter int SPEED_W      = 7,
    parameter int SPEED_MAX    = 100,
    parameter int HOLD_FRAMES  = 13
) (
    input  logic                clock,
    input  logic                resetn,
    colour_wheel_ctrl_if.master bus
);
    localparam int SW     = 4 * SCORE_DIGITS;
    localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_FALL  = 3'd2;
    localparam logic [2:0] S_OVER  = 3'd3;

    logic [2:0]         state;
    logic [IDX_W-1:0]   wheel;
    logic [SW-1:0]      score_r;
    logic [SW-1:0]      hscore_r;
    logic [SPEED_W-1:0] speed_r;
    logic               game_over_r;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               left_cur, left_prev;
    logic               right_cur, right_prev;

    logic               game_en_c;
    logic               left_edge, right_edge;
    logic               check_fire;
    logic               hit;
    logic [IDX_W-1:0]   wheel_dec, wheel_inc;

    // BCD +1 with ripple carry; an all-nines score is held rather than wrapped
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            r = v;
        end
        return r;
    endfunction

    // decode of enables, key edges and the hit condition
    always_comb begin
        game_en_c  = (state == S_SERVE) || (state == S_FALL);
        left_edge  = left_cur & ~left_prev;
        right_edge = right_cur & ~right_prev;
        check_fire = (state == S_FALL) && bus.frame_tick && bus.draw_done
                     && (bus.ball_y >= Y_W'(Y_HIT));
        hit        = (bus.ball_idx == wheel);
        wheel_dec  = (wheel == '0) ? IDX_W'(NUM_COLOURS - 1) : wheel - IDX_W'(1);
        wheel_inc  = (wheel == IDX_W'(NUM_COLOURS - 1)) ? '0 : wheel + IDX_W'(1);
    end

    // key history runs in every state so a key held across game start never steps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            left_cur   <= 1'b0;
            left_prev  <= 1'b0;
            right_cur  <= 1'b0;
            right_prev <= 1'b0;
        end else begin
            left_cur   <= bus.left;
            left_prev  <= left_cur;
            right_cur  <= bus.right;
            right_prev <= right_cur;
        end
    end

    // wheel rotation; the hit check in the same cycle still sees the old position
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wheel <= '0;
        end else if (state == S_IDLE && !bus.go) begin
            wheel <= '0;
        end else if (game_en_c && (left_edge ^ right_edge)) begin
            wheel <= left_edge ? wheel_dec : wheel_inc;
        end
    end

    // game sequencer with score, speed, high score and game-over hold timing
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            score_r     <= '0;
            hscore_r    <= '0;
            speed_r     <= SPEED_W'(1);
            game_over_r <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            game_over_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!bus.go) begin
                        score_r <= '0;
                        speed_r <= SPEED_W'(1);
                        state   <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    state <= S_FALL;
                end
                S_FALL: begin
                    if (check_fire) begin
                        if (hit) begin
                            score_r <= bcd_inc(score_r);
                            if (speed_r < SPEED_W'(SPEED_MAX)) begin
                                speed_r <= speed_r + SPEED_W'(1);
                            end
                            state <= S_SERVE;
                        end else begin
                            game_over_r <= 1'b1;
                            if (score_r > hscore_r) begin
                                hscore_r <= score_r;
                            end
                            hold_cnt <= '0;
                            state    <= S_OVER;
                        end
                    end
                end
                S_OVER: begin
                    if (bus.frame_tick) begin
                        if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                            hold_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // output mapping onto the interface
    always_comb begin
        bus.wheel_pos  = wheel;
        bus.game_en    = game_en_c;
        bus.new_col_en = (state == S_SERVE);
        bus.ball_en    = (state == S_FALL);
        bus.score      = score_r;
        bus.hscore     = hscore_r;
        bus.speed      = speed_r;
        bus.game_over  = game_over_r;
        bus.state_dbg  = state;
    end
endmodule

// File: tb/tb_colour_wheel_ctrl.sv
// tb/tb_colour_wheel_ctrl.sv - directed self-checking bench for colour_wheel_ctrl
module tb_colour_wheel_ctrl;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_n = 0;
    int   exp_speed = 1;
    int   exp_wheel = 0;

    colour_wheel_ctrl_if #(.IDX_W(3), .SCORE_DIGITS(2), .Y_W(7), .SPEED_W(7)) bus ();

    colour_wheel_ctrl #(
        .NUM_COLOURS(4), .IDX_W(3), .SCORE_DIGITS(2), .Y_W(7), .Y_HIT(119),
        .SPEED_W(7), .SPEED_MAX(100), .HOLD_FRAMES(13)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) % 10) * 16 + (n % 10));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        exp_n = 0;
        exp_speed = 1;
        exp_wheel = 0;
    endtask

    task automatic start_game();
        bus.go = 1'b0;
        step();
        bus.go = 1'b1;
        exp_n = 0;
        exp_speed = 1;
        exp_wheel = 0;
        checks++;
        if ({bus.state_dbg, bus.new_col_en, bus.game_en, bus.ball_en} !== {3'd1, 3'b110}) begin
            failures++;
            $display("FAIL serve got state=%0d new_col=%b game_en=%b ball_en=%b exp 1/1/1/0",
                     bus.state_dbg, bus.new_col_en, bus.game_en, bus.ball_en);
        end
        checks++;
        if ({bus.score, bus.speed, bus.wheel_pos} !== {8'h00, 7'd1, 3'd0}) begin
            failures++;
            $display("FAIL start_vals got score=%h speed=%0d wheel=%0d exp 00/1/0",
                     bus.score, bus.speed, bus.wheel_pos);
        end
        step();
        checks++;
        if ({bus.state_dbg, bus.new_col_en, bus.ball_en} !== {3'd2, 2'b01}) begin
            failures++;
            $display("FAIL fall_entry got state=%0d new_col=%b ball_en=%b exp 2/0/1",
                     bus.state_dbg, bus.new_col_en, bus.ball_en);
        end
    endtask

    task automatic do_hit();
        bus.ball_idx = 3'(exp_wheel);
        bus.ball_y = 7'd119;
        bus.draw_done = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        bus.ball_y = 7'd0;
        if (exp_n < 99) exp_n++;
        if (exp_speed < 100) exp_speed++;
        checks++;
        if ({bus.state_dbg, bus.score, bus.speed} !== {3'd1, to_bcd(exp_n), 7'(exp_speed)}) begin
            failures++;
            $display("FAIL hit got state=%0d score=%h speed=%0d exp 1/%h/%0d",
                     bus.state_dbg, bus.score, bus.speed, to_bcd(exp_n), exp_speed);
        end
        step();
    endtask

    task automatic do_miss(input int idx, input int exp_hs);
        bus.ball_idx = 3'(idx);
        bus.ball_y = 7'd120;
        bus.draw_done = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        bus.ball_y = 7'd0;
        checks++;
        if ({bus.state_dbg, bus.game_over, bus.new_col_en, bus.game_en, bus.hscore}
            !== {3'd3, 3'b100, to_bcd(exp_hs)}) begin
            failures++;
            $display("FAIL miss got state=%0d game_over=%b new_col=%b game_en=%b hscore=%h exp 3/1/0/0/%h",
                     bus.state_dbg, bus.game_over, bus.new_col_en, bus.game_en, bus.hscore, to_bcd(exp_hs));
        end
        step();
        checks++;
        if (bus.game_over !== 1'b0) begin
            failures++;
            $display("FAIL game_over_pulse got %b exp 0", bus.game_over);
        end
    endtask

    task automatic hold_out(input int exp_score);
        for (int i = 0; i < 12; i++) begin
            bus.right = (i == 0);
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
        bus.right = 1'b0;
        checks++;
        if ({bus.state_dbg, bus.wheel_pos} !== {3'd3, 3'(exp_wheel)}) begin
            failures++;
            $display("FAIL hold_12 got state=%0d wheel=%0d exp 3/%0d", bus.state_dbg, bus.wheel_pos, exp_wheel);
        end
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        checks++;
        if ({bus.state_dbg, bus.score} !== {3'd0, to_bcd(exp_score)}) begin
            failures++;
            $display("FAIL hold_13 got state=%0d score=%h exp 0/%h", bus.state_dbg, bus.score, to_bcd(exp_score));
        end
    endtask

    task automatic press(input logic l, input logic r, input int exp_w, input string name);
        bus.left = l;
        bus.right = r;
        step();
        step();
        exp_wheel = exp_w;
        checks++;
        if (bus.wheel_pos !== 3'(exp_w)) begin
            failures++;
            $display("FAIL %s got wheel=%0d exp %0d", name, bus.wheel_pos, exp_w);
        end
        bus.left = 1'b0;
        bus.right = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.state_dbg, bus.wheel_pos, bus.score, bus.hscore, bus.speed}
            !== {3'd0, 3'd0, 8'h00, 8'h00, 7'd1}) begin
            failures++;
            $display("FAIL reset_regs got state=%0d wheel=%0d score=%h hscore=%h speed=%0d exp 0/0/00/00/1",
                     bus.state_dbg, bus.wheel_pos, bus.score, bus.hscore, bus.speed);
        end
        checks++;
        if ({bus.game_en, bus.new_col_en, bus.ball_en, bus.game_over} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs got %b exp 0000",
                     {bus.game_en, bus.new_col_en, bus.ball_en, bus.game_over});
        end
        step();
        checks++;
        if (bus.state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL idle_hold got state=%0d exp 0", bus.state_dbg);
        end
    endtask

    task automatic test_hits();
        start_game();
        for (int i = 0; i < 9; i++) do_hit();
        bus.ball_y = 7'd119;
        bus.draw_done = 1'b0;
        bus.frame_tick = 1'b1;
        step();
        bus.ball_y = 7'd118;
        bus.draw_done = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        checks++;
        if ({bus.state_dbg, bus.score} !== {3'd2, 8'h09}) begin
            failures++;
            $display("FAIL no_check got state=%0d score=%h exp 2/09", bus.state_dbg, bus.score);
        end
        do_hit();
        checks++;
        if ({bus.score, bus.speed} !== {8'h10, 7'd11}) begin
            failures++;
            $display("FAIL carry got score=%h speed=%0d exp 10/11", bus.score, bus.speed);
        end
    endtask

    task automatic test_rotation();
        press(1'b0, 1'b1, 1, "right1");
        press(1'b0, 1'b1, 2, "right2");
        press(1'b0, 1'b1, 3, "right3");
        press(1'b0, 1'b1, 0, "right_wrap");
        press(1'b1, 1'b0, 3, "left_wrap");
        press(1'b1, 1'b1, 3, "both");
    endtask

    task automatic test_miss_hold();
        do_reset();
        start_game();
        for (int i = 0; i < 7; i++) do_hit();
        do_miss(1, 7);
        hold_out(7);
        start_game();
        for (int i = 0; i < 12; i++) do_hit();
        press(1'b0, 1'b1, 1, "pre_miss_right");
        do_miss(2, 12);
        hold_out(12);
        start_game();
        for (int i = 0; i < 5; i++) do_hit();
        do_miss(1, 12);
        checks++;
        if (bus.hscore !== 8'h12) begin
            failures++;
            $display("FAIL hscore_keep got %h exp 12", bus.hscore);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        start_game();
        for (int i = 0; i < 120; i++) do_hit();
        checks++;
        if ({bus.score, bus.speed} !== {8'h99, 7'd100}) begin
            failures++;
            $display("FAIL saturate got score=%h speed=%0d exp 99/100", bus.score, bus.speed);
        end
    endtask

    task automatic test_async_reset();
        do_miss(1, 99);
        hold_out(99);
        start_game();
        do_hit();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.state_dbg, bus.hscore, bus.score, bus.speed, bus.ball_en, bus.game_en}
            !== {3'd0, 8'h00, 8'h00, 7'd1, 2'b00}) begin
            failures++;
            $display("FAIL async_reset got state=%0d hscore=%h score=%h speed=%0d ball_en=%b game_en=%b exp 0/00/00/1/0/0",
                     bus.state_dbg, bus.hscore, bus.score, bus.speed, bus.ball_en, bus.game_en);
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (bus.state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL post_reset got state=%0d exp 0", bus.state_dbg);
        end
    endtask

    initial begin
        bus.go = 1'b1;
        bus.left = 1'b0;
        bus.right = 1'b0;
        bus.ball_y = 7'd0;
        bus.ball_idx = 3'd0;
        bus.draw_done = 1'b0;
        bus.frame_tick = 1'b0;
        test_reset();
        test_hits();
        test_rotation();
        test_miss_hold();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/colour_wheel_ctrl.md
Name: colour_wheel_ctrl

Overview:
- Parametrised game controller for the colour-wheel game.
- Sequences the game: idle, serve a ball, fall, hit/miss check, game-over hold.
- Owns wheel rotation over NUM_COLOURS segments, a BCD score with SCORE_DIGITS digits, high score, and a saturating fall-speed level.
- Sits between the key/switch inputs and the ball/wheel drawing datapath. It drives enables to that datapath and takes ball position and draw-complete status back from it.

Parameters:
- NUM_COLOURS, 4, number of wheel segments/colours (2..8)
- IDX_W, 3, width of colour index; must satisfy 2**IDX_W >= NUM_COLOURS
- SCORE_DIGITS, 2, number of BCD digits in score and high score (1..4)
- Y_W, 7, width of ball y coordinate
- Y_HIT, 119, y value at or beyond which the ball has reached the wheel
- SPEED_W, 7, width of speed level
- SPEED_MAX, 100, saturation value of speed level
- HOLD_FRAMES, 13, frames spent in game-over before returning to idle

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go  in  1  start key, active low (pressed = 0)
- left  in  1  rotate-left key, level; rising edge = one step
- right  in  1  rotate-right key, level; rising edge = one step
- ball_y  in  Y_W  current ball y
- ball_idx  in  IDX_W  colour index of current ball
- draw_done  in  1  all wheel segments finished drawing
- frame_tick  in  1  one-cycle pulse per display frame
- wheel_pos  out  IDX_W  colour index currently facing the ball
- game_en  out  1  high in SERVE and FALL
- new_col_en  out  1  one-cycle pulse requesting a new ball colour/position
- ball_en  out  1  ball motion enable (FALL only)
- score  out  4*SCORE_DIGITS  BCD score, digit 0 in LSBs
- hscore  out  4*SCORE_DIGITS  BCD high score
- speed  out  SPEED_W  fall-speed level
- game_over  out  1  one-cycle pulse on miss
- state_dbg  out  3  encoded current state

Behaviour:
Reset (resetn=0, asynchronous):
- State IDLE; wheel_pos=0, score=0, hscore=0, speed=1.
- All enables and pulses 0; edge-detect registers 0.
- A reset during any state aborts the game immediately. hscore is also cleared.

States, all transitions on the clock rising edge:
- IDLE (0): outputs idle. go==0 -> SERVE. On this transition: score:=0, speed:=1, wheel_pos:=0.
- SERVE (1): new_col_en=1 for exactly this cycle; game_en=1. Always -> FALL next cycle.
- FALL (2): game_en=1, ball_en=1. When frame_tick && ball_y>=Y_HIT && draw_done, do the hit check in that same cycle:
  - Hit (ball_idx==wheel_pos): score BCD +1 with digit carry; speed:=min(speed+1, SPEED_MAX); -> SERVE.
  - Miss: game_over=1 for one cycle; hscore:=score if score>hscore (plain unsigned compare is valid for BCD); -> OVER.
  - If the condition holds but draw_done=0, stay in FALL and re-check on the next qualifying frame_tick.
- OVER (3): game_en=0, ball_en=0. Count frame_tick pulses. After HOLD_FRAMES ticks -> IDLE. score stays visible until the next start.
- Codes 4-7 unused. If reached, -> IDLE next cycle.

Score arithmetic:
- Each digit 0..9; 9+1 -> 0 with carry into the next digit.
- All digits 9 saturates: no wrap, score held.

Rotation:
- left and right are registered once; a rising edge is detected as cur & ~prev. wheel_pos updates the cycle after the edge is detected.
- Left edge: wheel_pos := (wheel_pos==0) ? NUM_COLOURS-1 : wheel_pos-1.
- Right edge: wheel_pos := (wheel_pos==NUM_COLOURS-1) ? 0 : wheel_pos+1.
- Both edges in the same cycle: no change.
- Edges are ignored when game_en=0. Edge history still tracks, so a key held across the game start does not step.
- A rotation in the same cycle as the hit check: the check uses the pre-update wheel_pos.

Invariants:
- wheel_pos < NUM_COLOURS at all times.
- new_col_en and game_over are never high together.

Test Plan:
- Reset then go=0 for 1 cycle -> SERVE for exactly 1 cycle with new_col_en=1, then FALL; score=0x00, speed=1, wheel_pos=0.
- In FALL, ball_idx=0, wheel_pos=0, ball_y=119, draw_done=1, frame_tick pulse -> score=0x01, speed=2, state SERVE next cycle. Repeat to score 0x09 then one more hit -> 0x10.
- NUM_COLOURS=4: three right edges -> wheel_pos 1,2,3; fourth -> 0; one left edge from 0 -> 3. left and right rising in the same cycle -> unchanged.
- Score 0x12 with hscore 0x07, then a miss (ball_idx=2, wheel_pos=1) -> game_over pulse, hscore=0x12, OVER. After 13 frame_ticks -> IDLE; score still 0x12. A later game ending at 0x05 leaves hscore=0x12.
- 120 consecutive hits with SPEED_MAX=100 -> speed saturates at 100. Score at 0x99 plus a hit stays 0x99.
- Assert resetn=0 mid-FALL between clock edges -> outputs reset immediately, before the next clock edge; state IDLE, hscore=0.
